ps2_frame_rx: RTL and testbench
===============================

Name: ps2_frame_rx

Overview:
PS/2 device-to-host serial receiver for the keyboard path.
- Synchronizes and glitch-filters the ps2c/ps2d lines.
- Deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Presents each valid scan-code byte with a one-cycle strobe.
- Sits directly upstream of the break-code (0xF0) detector, which consumes rx_data.

Parameters:
- FILTER_LEN, 8: number of consecutive identical clk samples required before the filtered ps2c changes level.
- TIMEOUT_CYCLES, 100000: maximum clk cycles between ps2c falling edges inside a frame (used only with PS2_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- ps2c  in  1  raw PS/2 clock line, asynchronous.
- ps2d  in  1  raw PS/2 data line, asynchronous.
- rx_en  in  1  when 0, new frames are not started.
- rx_data  out  8  last valid received byte; held between frames.
- rx_done_tick  out  1  one-cycle pulse when rx_data is updated.
- parity_err  out  1  one-cycle pulse when a frame is discarded for bad parity.
- frame_err  out  1  one-cycle pulse when a frame is discarded for a bad stop bit (or timeout).
- busy  out  1  high while the FSM is outside IDLE.

Behaviour:
- Sync: ps2c and ps2d each pass through a 2-flop synchronizer before use.
- Filter:
  - FILTER_LEN-bit shift register of synchronized ps2c.
  - All ones sets filtered clock fc=1; all zeros sets fc=0; otherwise fc holds.
  - Falling edge fall = fc_prev & ~fc, one cycle wide.
  - ps2d is sampled (synchronized) in the cycle fall is high.
- FSM states IDLE, RECV, DONE.
  - IDLE: on fall with rx_en=1 and ps2d=0 (start bit): go to RECV, bit count=10, clear shift register.
    - fall with ps2d=1, or with rx_en=0: ignored, stay in IDLE.
  - RECV: on each fall, shift ps2d into the MSB of a 10-bit shift register and decrement the count. When the count reaches 0 (stop bit just sampled), go to DONE.
  - DONE (exactly one cycle), then IDLE:
    - Field order at this point: data = sr[7:0], parity = sr[8], stop = sr[9].
    - If stop=0: frame_err=1; rx_data unchanged.
    - Else if ^{data,parity}==0 (not odd): parity_err=1; rx_data unchanged.
    - Else: rx_data<=data and rx_done_tick=1.
    - A stop error takes priority over a parity error; only one pulse is raised per frame.
- Latency: rx_done_tick and rx_data update in the cycle after the fall that samples the stop bit.
- rx_en deasserted mid-frame does not abort the current frame.
- Reset:
  - Outputs: rx_data=0x00, rx_done_tick=0, parity_err=0, frame_err=0, busy=0.
  - Internal: FSM=IDLE, filter register all ones, fc=1, synchronizers=1.
  - Reset mid-frame discards the partial frame. The next full frame is received normally.
- Pulses never overlap. At most one of rx_done_tick, parity_err and frame_err is high in any cycle.

Optional Feature:
- PS2_TIMEOUT_EN defined:
  - Watchdog counter cleared on entry to RECV and on each fall in RECV; increments every cycle in RECV.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err for one cycle; no rx_done_tick.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter logic; RECV waits indefinitely for edges.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encoding (2-bit: IDLE=0, RECV=1, DONE=2);
  - FRAME_BITS=11;
  - BREAK_CODE=8'hF0, shared with the downstream detector.
- Sub-module ps2_clk_filter contains the synchronizers, the FILTER_LEN filter and fall generation. Outputs: fall, ps2d_s.

Test Plan:
- Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1), bit period 40 us → rx_data=0x1C; one rx_done_tick one cycle after the stop fall; no error pulses.
- Frame 0xF0 with parity 1 → rx_data=0xF0, one rx_done_tick; a following 0x1C frame → rx_data=0x1C, two ticks total.
- Frame 0x1C with parity 1 → parity_err pulse; rx_data keeps its previous value; no tick.
- Frame 0x1C with stop=0 → frame_err pulse only; rx_data unchanged.
- ps2c low glitch lasting FILTER_LEN-2 cycles mid-frame, then a valid 0x1C frame → no extra bit shifted; rx_data=0x1C.
- Reset asserted after the 4th data bit, then a full 0x5A frame → rx_data=0x5A, one tick. With PS2_TIMEOUT_EN: stop edges after bit 3 → frame_err pulse after TIMEOUT_CYCLES, busy=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 receive shared definitions: FSM encoding, frame geometry, break code.
// Latency: n/a (package only).
// Backpressure: n/a; consumers of rx_data cannot stall the PS/2 line.
package ps2_pkg;

    // Receiver FSM encoding, kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Shared with the downstream break-code detector.
    localparam logic [7:0] BREAK_CODE = 8'hF0;

    // PS/2 uses odd parity over data and parity bit together.
    function automatic logic odd_parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-flop synchronizers, ps2c run-length filter, falling-edge strobe.
// Latency: fall asserts FILTER_LEN+3 clk cycles after ps2c drops and stays low.
// Backpressure: none; free-running sampler, fall is a single-cycle strobe.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall,
    output logic ps2d_s
);

    logic                  c_meta_q, c_meta_d;
    logic                  c_sync_q, c_sync_d;
    logic                  d_meta_q, d_meta_d;
    logic                  d_sync_q, d_sync_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fc_q, fc_d;
    logic                  fc_prev_q, fc_prev_d;

    // Next-state: synchronizer shift, filter shift, hysteretic filtered clock.
    always_comb begin
        c_meta_d  = ps2c;
        c_sync_d  = c_meta_q;
        d_meta_d  = ps2d;
        d_sync_d  = d_meta_q;
        filt_d    = {filt_q[FILTER_LEN-2:0], c_sync_q};
        fc_d      = fc_q;
        // Only a full run of identical samples moves fc; mixed history holds it.
        if (&filt_q) begin
            fc_d = 1'b1;
        end else if (~|filt_q) begin
            fc_d = 1'b0;
        end
        fc_prev_d = fc_q;
    end

    // State registers; idle-high line levels after reset so no false edge appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_meta_q  <= 1'b1;
            c_sync_q  <= 1'b1;
            d_meta_q  <= 1'b1;
            d_sync_q  <= 1'b1;
            filt_q    <= '1;
            fc_q      <= 1'b1;
            fc_prev_q <= 1'b1;
        end else begin
            c_meta_q  <= c_meta_d;
            c_sync_q  <= c_sync_d;
            d_meta_q  <= d_meta_d;
            d_sync_q  <= d_sync_d;
            filt_q    <= filt_d;
            fc_q      <= fc_d;
            fc_prev_q <= fc_prev_d;
        end
    end

    assign fall   = fc_prev_q & ~fc_q;
    assign ps2d_s = d_sync_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver; optional watchdog via macro PS2_TIMEOUT_EN.
// Latency: rx_data/rx_done_tick (or error pulse) valid the cycle after the stop-bit fall.
// Backpressure: none; a byte is presented once with rx_done_tick and held until the next.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    // Elaboration-time sanity of the configuration.
    if (FILTER_LEN < 2) begin : g_filter_len_check
        $error("FILTER_LEN must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic fall;
    logic ps2d_s;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .ps2c   (ps2c),
        .ps2d   (ps2d),
        .fall   (fall),
        .ps2d_s (ps2d_s)
    );

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] sr_q, sr_d;
    logic [9:0] sr_shift;
    logic [7:0] rx_data_q, rx_data_d;
    logic       tick_q, tick_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       wd_expired;

`ifdef PS2_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q, wd_d;

    // Watchdog restarts on every edge inside a frame and sits at zero elsewhere,
    // which also covers the clear on entry to RECV.
    always_comb begin
        wd_d = '0;
        if (state_q == ST_RECV && !fall) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign wd_expired = (state_q == ST_RECV) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    // Receive FSM. The verdict is computed on the stop-bit edge and registered,
    // so the pulse and the new rx_data appear together during the single DONE cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        rx_data_d = rx_data_q;
        tick_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        sr_shift  = {ps2d_s, sr_q[9:1]};

        case (state_q)
            ST_IDLE: begin
                if (fall && rx_en && !ps2d_s) begin
                    state_d = ST_RECV;
                    cnt_d   = 4'(FRAME_BITS - 1);
                    sr_d    = '0;
                end
            end
            ST_RECV: begin
                if (wd_expired) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else if (fall) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_DONE;
                        // sr_shift layout: [9]=stop, [8]=parity, [7:0]=data.
                        if (!sr_shift[9]) begin
                            ferr_d = 1'b1;
                        end else if (!odd_parity_ok(sr_shift[8:0])) begin
                            perr_d = 1'b1;
                        end else begin
                            rx_data_d = sr_shift[7:0];
                            tick_d    = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, datapath and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            rx_data_q <= 8'h00;
            tick_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            rx_data_q <= rx_data_d;
            tick_q    <= tick_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_done_tick = tick_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: good frames, parity/stop errors, glitch, rx_en, reset, timeout.
// Bit half-period is shortened to HP clk cycles to keep the run short.
// Pulses are counted on the falling clock edge; expected values are hand-derived.
module tb_ps2_frame_rx;

    localparam int FL  = 8;
    localparam int TO  = 600;
    localparam int HP  = 20;
    // ps2c drop -> 2 sync + FL filter + fc + fall registers -> pulse visible.
    localparam int LAT = FL + 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    ps2_frame_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .rx_en        (rx_en),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_tick    = 0;
    int n_perr    = 0;
    int n_ferr    = 0;
    int n_overlap = 0;
    int b_tick, b_perr, b_ferr;
    int stop_lat;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Pulse bookkeeping, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_done_tick) n_tick++;
            if (parity_err)   n_perr++;
            if (frame_err)    n_ferr++;
            if (int'(rx_done_tick) + int'(parity_err) + int'(frame_err) > 1) n_overlap++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_tick = n_tick;
        b_perr = n_perr;
        b_ferr = n_ferr;
    endtask

    // Sends the first nbits bits of a frame; glitch_bit >= 0 inserts a short
    // ps2c low pulse while the clock is high just before that bit's real edge.
    task automatic send_frame(input logic [7:0] dat, input logic par, input logic stp,
                              input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {stp, par, dat, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (i == glitch_bit) begin
                wait_cyc(HP);
                ps2c = 1'b0;
                wait_cyc(FL - 2);
                ps2c = 1'b1;
            end
            wait_cyc(HP);
            ps2c = 1'b0;
            if (i == 10) begin
                stop_lat = -1;
                for (int k = 1; k <= HP; k++) begin
                    @(posedge clk);
                    #1;
                    if (stop_lat < 0 && (rx_done_tick || parity_err || frame_err)) stop_lat = k;
                end
            end else begin
                wait_cyc(HP);
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        wait_cyc(2 * HP);
    endtask

    initial begin
        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b1;
        wait_cyc(5);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_tick", int'(rx_done_tick), 0);
        check("reset_perr", int'(parity_err), 0);
        check("reset_ferr", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        wait_cyc(5);

        // Good 0x1C frame (3 ones -> parity 0).
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        check("f1c_data", int'(rx_data), 8'h1C);
        check("f1c_ticks", n_tick - b_tick, 1);
        check("f1c_perr", n_perr - b_perr, 0);
        check("f1c_ferr", n_ferr - b_ferr, 0);
        check("f1c_latency", stop_lat, LAT);
        check("f1c_busy_after", int'(busy), 0);

        // Break code then 0x1C.
        snap();
        send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
        check("ff0_data", int'(rx_data), 8'hF0);
        check("ff0_ticks", n_tick - b_tick, 1);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        check("pair_data", int'(rx_data), 8'h1C);
        check("pair_ticks", n_tick - b_tick, 2);

        // Bad parity: rx_data must keep the prior 0xF0.
        send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
        snap();
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
        check("par_perr", n_perr - b_perr, 1);
        check("par_ticks", n_tick - b_tick, 0);
        check("par_ferr", n_ferr - b_ferr, 0);
        check("par_data", int'(rx_data), 8'hF0);
        check("par_latency", stop_lat, LAT);

        // Bad stop bit, parity also bad: only frame_err.
        snap();
        send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
        check("stop_ferr", n_ferr - b_ferr, 1);
        check("stop_perr", n_perr - b_perr, 0);
        check("stop_ticks", n_tick - b_tick, 0);
        check("stop_data", int'(rx_data), 8'hF0);

        // Short ps2c glitch inside a frame must not shift a bit.
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 11, 4);
        check("glitch_data", int'(rx_data), 8'h1C);
        check("glitch_ticks", n_tick - b_tick, 1);
        check("glitch_errs", (n_perr - b_perr) + (n_ferr - b_ferr), 0);

        // rx_en low: frame ignored.
        rx_en = 1'b0;
        snap();
        send_frame(8'h5A, 1'b1, 1'b1, 11, -1);
        check("dis_ticks", n_tick - b_tick, 0);
        check("dis_data", int'(rx_data), 8'h1C);
        check("dis_busy", int'(busy), 0);
        rx_en = 1'b1;

        // Reset after 4 data bits, then a full 0x5A frame.
        send_frame(8'h5A, 1'b1, 1'b1, 5, -1);
        check("partial_busy", int'(busy), 1);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_data", int'(rx_data), 0);
        snap();
        send_frame(8'h5A, 1'b1, 1'b1, 11, -1);
        check("f5a_data", int'(rx_data), 8'h5A);
        check("f5a_ticks", n_tick - b_tick, 1);
        check("f5a_errs", (n_perr - b_perr) + (n_ferr - b_ferr), 0);

`ifdef PS2_TIMEOUT_EN
        // Edges stop after data bit 3; watchdog must close the frame.
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 4, -1);
        check("to_busy_before", int'(busy), 1);
        wait_cyc(TO + 50);
        check("to_ferr", n_ferr - b_ferr, 1);
        check("to_ticks", n_tick - b_tick, 0);
        check("to_busy_after", int'(busy), 0);
        check("to_data", int'(rx_data), 8'h5A);
`endif

        check("no_overlap", n_overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
